// File: rtl/spongent_arb_pkg.sv
// spongent_arb_pkg: shared types and constants for the spongent arbiter
//   arb_state_t     : arbiter FSM states
//   DEFAULT_TIMEOUT : default watchdog limit in cycles
package spongent_arb_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} arb_state_t;
    localparam int DEFAULT_TIMEOUT = 4096;
endpackage

// File: rtl/spongent_arbiter_rr_priority_encoder.sv
// rr_priority_encoder: first requesting index at or after rr_ptr, wrapping
//   req    in  NUM_REQ  request bits
//   rr_ptr in  IW       search start index
//   valid  out 1        any request present
//   idx    out IW       selected index
module rr_priority_encoder #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               valid,
    output logic [IW-1:0]      idx
);
    localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        ff;
    logic [IW:0]          sum;
    // rotating the doubled vector puts rr_ptr at bit 0
    assign dbl   = {req, req} >> rr_ptr;
    assign rot   = dbl[NUM_REQ-1:0];
    assign valid = |req;
    always_comb begin
        ff = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) ff = i[IW-1:0];
    end
    assign sum = {1'b0, ff} + {1'b0, rr_ptr};
    assign idx = sum >= NR ? IW'(sum - NR) : sum[IW-1:0];
endmodule

// File: rtl/spongent_arbiter.sv
// spongent_arbiter: round-robin sharing of one spongent core among NUM_REQ requesters
//   req/msg_in      : requester levels and packed messages
//   grant/done      : one-hot grant, one-cycle completion pulse
//   hash_out        : last captured digest
//   busy            : high outside IDLE
//   timeout_err     : sticky watchdog flag (SPONGENT_ARB_TIMEOUT_EN), else 0
//   core_rst/core_msg/core_hash/core_end : spongent core connection
module spongent_arbiter
    import spongent_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MSG_WIDTH      = 128,
    parameter int N              = 128,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*MSG_WIDTH-1:0] msg_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic [N-1:0]                 hash_out,
    output logic                         busy,
    output logic                         timeout_err,
    output logic                         core_rst,
    output logic [MSG_WIDTH-1:0]         core_msg,
    input  logic [N-1:0]                 core_hash,
    input  logic                         core_end
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
    arb_state_t state, state_nx;
    logic [IW-1:0] rr_ptr, grant_idx, pick_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic pick_valid, tmo;

    rr_priority_encoder #(.NUM_REQ(NUM_REQ)) u_enc (
        .req(req), .rr_ptr(rr_ptr), .valid(pick_valid), .idx(pick_idx)
    );

    assign grant_oh = NUM_REQ'(1) << grant_idx;

`ifdef SPONGENT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic tmo_flag;
    // counter is zero outside RUN, so it starts fresh on every RUN entry
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_cnt <= state == RUN ? tmo_cnt + 1'b1 : '0;
            if (tmo && !core_end) tmo_flag <= 1'b1;
        end
    end
    assign tmo = state == RUN && tmo_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign timeout_err = tmo_flag;
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            hash_out  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_valid) grant_idx <= pick_idx;
            if (state == RUN && core_end) hash_out <= core_hash;
            if (state == DONE) rr_ptr <= grant_idx == LAST ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        state_nx = state == IDLE ? (pick_valid ? LOAD : IDLE) :
                   state == LOAD ? RUN :
                   state == RUN  ? ((core_end || tmo) ? DONE : RUN) : IDLE;
    end

    // DONE is only reachable from RUN, so done is a single-cycle pulse
    always_comb begin
        grant    = (state == LOAD || state == RUN) ? grant_oh : '0;
        done     = state == DONE ? grant_oh : '0;
        busy     = state != IDLE;
        core_rst = state != RUN;
        core_msg = state == IDLE ? '0 : msg_in[grant_idx*MSG_WIDTH +: MSG_WIDTH];
    end
endmodule
